// File: rtl/mem_ctrl_responder.sv
// Memory-controller end of the MemCommon link: one request at a time, fixed wait
// states, word-organised storage with alignment/range error checking.
module mem_ctrl_responder #(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 32,
  parameter int Depth      = 64,
  parameter int WaitStates = 1
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 req,
  input  logic [AddrWidth-1:0] addr,
  input  logic [DataWidth-1:0] wData,
  input  logic                 write,
  output logic [1:0]           resp,
  output logic [DataWidth-1:0] rData
);
  localparam int B  = $clog2(DataWidth / 8);
  localparam int IW = $clog2(Depth);
  localparam logic [AddrWidth:0]   LIMIT = (AddrWidth + 1)'(Depth * (DataWidth / 8));
  localparam logic [AddrWidth-1:0] ALIGN = AddrWidth'((1 << B) - 1);
  localparam logic [7:0]           WS    = 8'(WaitStates);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t               state;
  logic [7:0]           cnt;
  logic [AddrWidth-1:0] lat_addr;
  logic [DataWidth-1:0] lat_wdata;
  logic                 lat_write;
  logic [DataWidth-1:0] mem [Depth];

  logic [AddrWidth-1:0] acc_addr;
  logic [DataWidth-1:0] acc_wdata;
  logic                 acc_write;
  logic                 acc_err;
  logic [IW-1:0]        acc_idx;
  logic                 go_done;

  // With zero wait states the access completes on the accepting edge, so it
  // must use the live inputs rather than the (not yet loaded) latches.
  always_comb begin
    acc_addr  = (state == IDLE) ? addr  : lat_addr;
    acc_wdata = (state == IDLE) ? wData : lat_wdata;
    acc_write = (state == IDLE) ? write : lat_write;
    acc_err   = (|(acc_addr & ALIGN)) || ({1'b0, acc_addr} >= LIMIT);
    acc_idx   = acc_addr[B +: IW];
    go_done   = ((state == IDLE) && req && (WS == 8'd0)) ||
                ((state == WAIT) && (cnt == 8'd1));
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      resp      <= 2'b00;
      rData     <= '0;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_write <= 1'b0;
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          lat_addr  <= addr;
          lat_wdata <= wData;
          lat_write <= write;
          cnt       <= WS;
          state     <= WAIT;
          resp      <= 2'b01;
        end
        WAIT: cnt <= cnt - 8'd1;
        default: begin
          state <= IDLE;
          resp  <= 2'b00;
        end
      endcase
      // Completion overrides the state update above and applies side effects.
      if (go_done) begin
        state <= DONE;
        resp  <= acc_err ? 2'b11 : 2'b10;
        if (!acc_err) begin
          if (acc_write) mem[acc_idx] <= acc_wdata;
          else           rData        <= mem[acc_idx];
        end else if (!acc_write) begin
          rData <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_ctrl_responder.sv
// Bench for mem_ctrl_responder: three instances (WaitStates 0/1/2) checked
// against vector tables, hand sequences and a randomized array-based model.
module tb_mem_ctrl_responder;
  logic        clk = 1'b0;
  logic        nReset;
  logic [31:0] addr, wData;
  logic        write;
  logic        req0, req1, req2;
  logic [1:0]  resp0, resp1, resp2;
  logic [31:0] rdata0, rdata1, rdata2;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem_m [3][64];
  logic [31:0] rd_m  [3];

  always #5 clk = ~clk;

  mem_ctrl_responder #(.WaitStates(0)) u_ws0 (.clk(clk), .nReset(nReset), .req(req0), .addr(addr),
    .wData(wData), .write(write), .resp(resp0), .rData(rdata0));
  mem_ctrl_responder #(.WaitStates(1)) u_ws1 (.clk(clk), .nReset(nReset), .req(req1), .addr(addr),
    .wData(wData), .write(write), .resp(resp1), .rData(rdata1));
  mem_ctrl_responder #(.WaitStates(2)) u_ws2 (.clk(clk), .nReset(nReset), .req(req2), .addr(addr),
    .wData(wData), .write(write), .resp(resp2), .rData(rdata2));

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  er;
    logic [31:0] ed;
  } vec_t;

  function automatic logic [1:0] get_resp(int k);
    case (k)
      0: return resp0;
      1: return resp1;
      default: return resp2;
    endcase
  endfunction

  function automatic logic [31:0] get_rdata(int k);
    case (k)
      0: return rdata0;
      1: return rdata1;
      default: return rdata2;
    endcase
  endfunction

  task automatic set_req(int k, logic v);
    case (k)
      0: req0 = v;
      1: req1 = v;
      default: req2 = v;
    endcase
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_models();
    for (int k = 0; k < 3; k++) begin
      rd_m[k] = '0;
      for (int i = 0; i < 64; i++) mem_m[k][i] = '0;
    end
  endtask

  // Reference: 4-byte words, 64 deep -> byte limit 256.
  task automatic model(int k, bit wr, logic [31:0] a, logic [31:0] d,
                       output logic [1:0] er, output logic [31:0] ed);
    bit err;
    int idx;
    err = (a % 4 != 0) || (a >= 32'd256);
    idx = int'((a / 4) % 64);
    if (err) begin
      er = 2'b11;
      if (!wr) rd_m[k] = '0;
    end else begin
      er = 2'b10;
      if (wr) mem_m[k][idx] = d;
      else    rd_m[k] = mem_m[k][idx];
    end
    ed = rd_m[k];
  endtask

  // One request to instance k (WaitStates == k); checks the whole resp timeline.
  task automatic txn(int k, bit wr, logic [31:0] a, logic [31:0] d,
                     logic [1:0] er, logic [31:0] ed, string nm);
    @(negedge clk);
    write = wr; addr = a; wData = d;
    set_req(k, 1'b1);
    @(negedge clk);
    set_req(k, 1'b0);
    addr = $urandom; wData = $urandom; write = 1'($urandom);
    for (int j = 1; j <= k; j++) begin
      chk({nm, " wait"}, 32'(get_resp(k)), 32'd1);
      @(negedge clk);
    end
    chk({nm, " resp"}, 32'(get_resp(k)), 32'(er));
    chk({nm, " rdata"}, get_rdata(k), ed);
    @(negedge clk);
    chk({nm, " idle"}, 32'(get_resp(k)), 32'd0);
    chk({nm, " hold"}, get_rdata(k), ed);
  endtask

  task automatic mtxn(int k, bit wr, logic [31:0] a, logic [31:0] d, string nm);
    logic [1:0]  er;
    logic [31:0] ed;
    model(k, wr, a, d, er, ed);
    txn(k, wr, a, d, er, ed, nm);
  endtask

  initial begin
    vec_t        tbl [6];
    logic [1:0]  er;
    logic [31:0] ed, a;

    tbl[0] = '{1'b1, 32'h10,       32'hDEADBEEF, 2'b10, 32'h0};
    tbl[1] = '{1'b0, 32'h10,       32'h0,        2'b10, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 32'h11,       32'h12345678, 2'b11, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 32'h10,       32'h0,        2'b10, 32'hDEADBEEF};
    tbl[4] = '{1'b0, 32'h100,      32'h0,        2'b11, 32'h0};
    tbl[5] = '{1'b0, 32'h80000000, 32'h0,        2'b11, 32'h0};

    nReset = 1'b0; req0 = 0; req1 = 0; req2 = 0;
    addr = '0; wData = '0; write = 0;
    clear_models();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset resp", 32'(get_resp(k)), 32'd0);
      chk("reset rdata", get_rdata(k), 32'd0);
    end
    nReset = 1'b1;

    mtxn(1, 1'b0, 32'h3C, 32'h0, "post-reset read 3C");

    // Table on the WaitStates=2 instance; keep its model in step.
    for (int i = 0; i < 6; i++) begin
      model(2, tbl[i].wr, tbl[i].a, tbl[i].d, er, ed);
      txn(2, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].er, tbl[i].ed, $sformatf("tbl%0d", i));
    end

    mtxn(0, 1'b1, 32'h04, 32'hA5A5F00D, "ws0 write 04");
    mtxn(0, 1'b0, 32'h04, 32'h0, "ws0 read 04");

    // Held req on zero-wait: only inputs present in IDLE are taken.
    @(negedge clk);
    write = 1'b1; addr = 32'h20; wData = 32'h11111111; req0 = 1'b1;
    @(negedge clk);
    chk("hold done0", 32'(resp0), 32'd2);
    addr = 32'h24; wData = 32'h22222222;
    @(negedge clk);
    chk("hold idle0", 32'(resp0), 32'd0);
    addr = 32'h28; wData = 32'h33333333;
    @(negedge clk);
    chk("hold done1", 32'(resp0), 32'd2);
    addr = 32'h24; wData = 32'h44444444; req0 = 1'b0;
    @(negedge clk);
    chk("hold idle1", 32'(resp0), 32'd0);
    model(0, 1'b1, 32'h20, 32'h11111111, er, ed);
    model(0, 1'b1, 32'h28, 32'h33333333, er, ed);
    mtxn(0, 1'b0, 32'h20, 32'h0, "hold rd 20");
    mtxn(0, 1'b0, 32'h24, 32'h0, "hold rd 24");
    mtxn(0, 1'b0, 32'h28, 32'h0, "hold rd 28");

    // Randomized traffic on every instance.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 40; n++) begin
        case ($urandom % 4)
          0, 1: a = ($urandom % 64) * 4;
          2:    a = ($urandom % 256) | 32'h1;
          default: a = 32'd256 + ($urandom % 1024);
        endcase
        if (($urandom % 16) == 0) a = $urandom | 32'h80000000;
        mtxn(k, 1'($urandom), a, $urandom, $sformatf("rnd k%0d n%0d", k, n));
      end
    end

    // Abort a write in WAIT on the WaitStates=2 instance.
    @(negedge clk);
    write = 1'b1; addr = 32'h08; wData = 32'hCAFEBABE; req2 = 1'b1;
    @(negedge clk);
    req2 = 1'b0;
    chk("abort wait", 32'(resp2), 32'd1);
    nReset = 1'b0;
    #1;
    chk("abort resp", 32'(resp2), 32'd0);
    @(negedge clk);
    chk("abort stays idle", 32'(resp2), 32'd0);
    nReset = 1'b1;
    clear_models();
    repeat (3) @(negedge clk);
    chk("abort no pulse", 32'(resp2), 32'd0);
    mtxn(2, 1'b0, 32'h08, 32'h0, "abort rd 08");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
